pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer that replaces the fixed 32-bit, zero-flag-only PC register in the fetch stage. It computes the next fetch address from a branch-mode code and supports relative and absolute jumps, both branch polarities, stall/hold and call/return through an internal return-address stack (RAS). It has one clock and one reset, all outputs are registered, and it feeds the instruction-memory address directly.

## Interface
Parameters:
- PC_W, 32 — PC width in bits; PC arithmetic is modulo 2^PC_W.
- IMM_W, 8 — relative-offset width; two's-complement, sign-extended to PC_W.
- RAS_DEPTH, 4 — return-address stack entries, ≥ 2.

Ports:
- clk  in  1  — rising-edge clock.
- reset  in  1  — asynchronous, active-high.
- should_run_processor  in  1  — while low, the next edge synchronously clears the PC, the RAS, the flags and `taken`.
- stall  in  1  — while high, all state holds.
- br_mode  in  3 (pc_pkg::br_mode_t)  — control flow for this cycle.
- zero  in  1  — ALU zero flag.
- immediate  in  IMM_W  — signed relative offset.
- abs_target  in  PC_W  — absolute jump target.
- current_pc_out  out  PC_W  — current fetch address.
- taken  out  1  — high when the last applied update was a redirect (anything other than PC+1).
- ras_count  out  $clog2(RAS_DEPTH+1)  — number of valid RAS entries.
- ras_overflow  out  1  — sticky: a CALL was issued while the RAS was full.
- ras_underflow  out  1  — sticky: a RET was issued while the RAS was empty.

## Operation
- Update priority at each edge: reset (asynchronous) > !should_run_processor > stall > br_mode.
- Definitions: seq = PC+1; rel = PC+1+sext(immediate). All sums are truncated to PC_W and wrap silently.
- br_mode behaviour:
  - NONE: next = seq.
  - BEQ: next = zero ? rel : seq.
  - BNE: next = !zero ? rel : seq.
  - JREL: next = rel.
  - JABS: next = abs_target.
  - CALL: push seq, then next = rel.
  - RET: pop the top entry; next = popped value.
- Encodings 7 and any unlisted value behave as NONE.
- RAS is a circular LIFO.
  - CALL when full: overwrite the oldest entry, keep ras_count = RAS_DEPTH, set ras_overflow.
  - RET when empty: next = seq, ras_underflow set, taken = 0, ras_count stays 0.
- taken = 1 for any PC value other than seq, including BEQ/BNE taken, JREL, JABS, CALL, and RET that pops. A JREL with immediate = -1 yields next = PC and still counts as taken.
- Stall: PC, RAS, ras_count, flags and taken all hold. Mode inputs are ignored.
- Sticky flags clear only on reset or when should_run_processor is low.

## Timing
- Reset values: current_pc_out = 0, taken = 0, ras_count = 0, ras_overflow = 0, ras_underflow = 0. RAS contents are don't-care.
- Latency: inputs sampled at edge N appear on the outputs after edge N. The block performs no combinational input-to-output path.
- Exactly one PC update per non-stalled edge; no multi-cycle operations.
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for a clock edge.
- First edge after reset deasserts with run high and mode NONE: PC = 1.
- should_run_processor low takes precedence over stall.

## Structure
- pc_pkg holds:
  - the br_mode_t enum: NONE = 0, BEQ = 1, BNE = 2, JREL = 3, JABS = 4, CALL = 5, RET = 6;
  - a localparam for the RAS pointer width.
- Sub-module pc_ras (parameters PC_W and RAS_DEPTH):
  - inputs push, pop, push_data, clear;
  - outputs top, count, full, empty;
  - this holds the circular storage and the pointer logic.
- The top level holds the next-PC mux, the priority logic and the flags.

## Test plan
- Reset, then run = 1 with NONE for 3 edges → PC goes 1, 2, 3; taken = 0.
- PC = 10, BEQ, zero = 1, immediate = 0xFB (-5) → PC = 6, taken = 1. Same inputs with zero = 0 → PC = 11, taken = 0. BNE with zero = 0 → PC = 6.
- PC = 20, CALL with immediate = 9 → PC = 30, ras_count = 1. Then RET → PC = 21, ras_count = 0.
- With RAS_DEPTH = 4, issue 5 nested CALLs → ras_overflow = 1, ras_count = 4. Then 4 RETs return the 2nd through 5th return addresses in LIFO order. A 5th RET → PC = PC+1, ras_underflow = 1.
- PC = 2^PC_W−1 with NONE → PC = 0. JABS with abs_target = 0x100 while stall = 1 → PC holds. On release → PC = 0x100.
- Drop should_run_processor while ras_count = 2 and both flags are set → after one edge, PC = 0, ras_count = 0, flags = 0. Assert reset between edges → outputs clear asynchronously.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and sizing helpers for the program-counter sequencer.
//   br_mode_t   - per-cycle control-flow selector
//   RAS_DEPTH_DEF / RAS_PTR_W - default return-stack depth and its pointer width
//   ras_ptr_w() - pointer width for an arbitrary return-stack depth
package pc_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_JREL = 3'd3,
    BR_JABS = 3'd4,
    BR_CALL = 3'd5,
    BR_RET  = 3'd6
  } br_mode_t;

  localparam int unsigned RAS_DEPTH_DEF = 4;
  localparam int unsigned RAS_PTR_W     = $clog2(RAS_DEPTH_DEF);

  // Pointer width for a stack of the given depth (depth >= 2)
  function automatic int unsigned ras_ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and status outputs of the PC sequencer.
//   master - fetch controller side: drives run/stall/mode/operands, reads PC and status
//   slave  - sequencer side
interface pc_sequencer_if
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned IMM_W     = 8,
  parameter int unsigned RAS_DEPTH = 4
);

  logic                           should_run_processor;
  logic                           stall;
  br_mode_t                       br_mode;
  logic                           zero;
  logic [IMM_W-1:0]               immediate;
  logic [PC_W-1:0]                abs_target;
  logic [PC_W-1:0]                current_pc_out;
  logic                           taken;
  logic [$clog2(RAS_DEPTH+1)-1:0] ras_count;
  logic                           ras_overflow;
  logic                           ras_underflow;

  modport master (
    output should_run_processor, stall, br_mode, zero, immediate, abs_target,
    input  current_pc_out, taken, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  should_run_processor, stall, br_mode, zero, immediate, abs_target,
    output current_pc_out, taken, ras_count, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular LIFO return-address stack.
//   push/push_data - store a return address; when full the oldest entry is overwritten
//   pop            - discard the top entry (ignored when empty)
//   clear          - synchronous flush, wins over push/pop
//   top            - current top entry (valid when !empty)
//   count/full/empty - occupancy
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           clear,
  input  logic [PC_W-1:0]                push_data,
  output logic [PC_W-1:0]                top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned PTR_W = ras_ptr_w(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_idx, wr_inc;
  logic [CNT_W-1:0] count_q, count_d;

  // Slot below the write pointer holds the top; both wrap at RAS_DEPTH
  always_comb begin
    rd_idx = (wr_ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : wr_ptr_q - PTR_W'(1);
    wr_inc = (wr_ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
  end

  assign full  = (count_q == CNT_W'(RAS_DEPTH));
  assign empty = (count_q == '0);
  assign top   = mem[rd_idx];
  assign count = count_q;

  // Next pointer/occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (push) begin
      wr_ptr_d = wr_inc;
      count_d  = full ? count_q : count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      wr_ptr_d = rd_idx;
      count_d  = count_q - CNT_W'(1);
    end
  end

  // Pointer/occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents need no reset since count gates validity
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with branches, jumps and call/return.
//   clk, reset     - rising-edge clock, asynchronous active-high reset
//   bus (slave)    - run/stall/br_mode/zero/immediate/abs_target in;
//                    current_pc_out/taken/ras_count/ras_overflow/ras_underflow out
// All outputs are registered; priority is reset > !run > stall > br_mode.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned IMM_W     = 8,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic [PC_W-1:0] seq_pc, rel_pc, ras_top;
  logic            ras_push, ras_pop, ras_clear, ras_full, ras_empty;
  logic [$clog2(RAS_DEPTH+1)-1:0] ras_count;

  assign seq_pc = pc_q + PC_W'(1);
  assign rel_pc = seq_pc + PC_W'($signed(bus.immediate));

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (ras_clear),
    .push_data (seq_pc),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // Next-PC mux, redirect indication and stack control
  always_comb begin
    pc_d      = pc_q;
    taken_d   = taken_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_clear = 1'b0;

    if (!bus.should_run_processor) begin
      pc_d      = '0;
      taken_d   = 1'b0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      ras_clear = 1'b1;
    end else if (!bus.stall) begin
      pc_d    = seq_pc;
      taken_d = 1'b0;
      case (bus.br_mode)
        BR_BEQ: if (bus.zero) begin
          pc_d    = rel_pc;
          taken_d = 1'b1;
        end
        BR_BNE: if (!bus.zero) begin
          pc_d    = rel_pc;
          taken_d = 1'b1;
        end
        BR_JREL: begin
          pc_d    = rel_pc;
          taken_d = 1'b1;
        end
        BR_JABS: begin
          pc_d    = bus.abs_target;
          taken_d = 1'b1;
        end
        BR_CALL: begin
          ras_push = 1'b1;
          ovf_d    = ovf_q | ras_full;
          pc_d     = rel_pc;
          taken_d  = 1'b1;
        end
        BR_RET: begin
          // Empty stack falls through to seq and flags the underflow
          if (ras_empty) begin
            unf_d = 1'b1;
          end else begin
            ras_pop = 1'b1;
            pc_d    = ras_top;
            taken_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // PC and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.current_pc_out = pc_q;
  assign bus.taken          = taken_q;
  assign bus.ras_count      = ras_count;
  assign bus.ras_overflow   = ovf_q;
  assign bus.ras_underflow  = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer. A behavioural model computes
// the expected outputs when each cycle's stimulus is driven; they are queued and
// compared after the following rising edge.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int unsigned PC_W      = 32;
  localparam int unsigned IMM_W     = 8;
  localparam int unsigned RAS_DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(PC_W), .IMM_W(IMM_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

  pc_sequencer #(.PC_W(PC_W), .IMM_W(IMM_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            taken;
    int unsigned     cnt;
    logic            ovf;
    logic            unf;
  } exp_t;

  exp_t sb[$];

  logic [PC_W-1:0] m_pc;
  logic            m_taken, m_ovf, m_unf;
  logic [PC_W-1:0] m_ras[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_taken = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_ras.delete();
  endtask

  // Reference behaviour for one edge
  task automatic model_edge(input logic run, input logic stl, input logic [2:0] mode,
                            input logic z, input logic [7:0] imm, input logic [31:0] abs_t);
    logic [31:0] seq, rel;
    seq = m_pc + 32'd1;
    rel = seq + {{24{imm[7]}}, imm};
    if (!run) begin
      model_reset();
    end else if (!stl) begin
      m_pc = seq; m_taken = 1'b0;
      case (mode)
        3'd1: if (z)  begin m_pc = rel; m_taken = 1'b1; end
        3'd2: if (!z) begin m_pc = rel; m_taken = 1'b1; end
        3'd3: begin m_pc = rel; m_taken = 1'b1; end
        3'd4: begin m_pc = abs_t; m_taken = 1'b1; end
        3'd5: begin
          if (m_ras.size() == RAS_DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_ras.push_back(seq);
          m_pc = rel; m_taken = 1'b1;
        end
        3'd6: begin
          if (m_ras.size() == 0) m_unf = 1'b1;
          else begin m_pc = m_ras.pop_back(); m_taken = 1'b1; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input string tag, input logic run, input logic stl, input logic [2:0] mode,
                      input logic z, input logic [7:0] imm, input logic [31:0] abs_t);
    exp_t e;
    bus.should_run_processor = run;
    bus.stall      = stl;
    bus.br_mode    = br_mode_t'(mode);
    bus.zero       = z;
    bus.immediate  = imm;
    bus.abs_target = abs_t;
    model_edge(run, stl, mode, z, imm, abs_t);
    e.pc = m_pc; e.taken = m_taken; e.cnt = m_ras.size(); e.ovf = m_ovf; e.unf = m_unf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".pc"},    64'(bus.current_pc_out), 64'(e.pc));
    check({tag, ".taken"}, 64'(bus.taken),          64'(e.taken));
    check({tag, ".cnt"},   64'(bus.ras_count),      64'(e.cnt));
    check({tag, ".ovf"},   64'(bus.ras_overflow),   64'(e.ovf));
    check({tag, ".unf"},   64'(bus.ras_underflow),  64'(e.unf));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".pc"},    64'(bus.current_pc_out), 64'd0);
    check({tag, ".taken"}, 64'(bus.taken),          64'd0);
    check({tag, ".cnt"},   64'(bus.ras_count),      64'd0);
    check({tag, ".ovf"},   64'(bus.ras_overflow),   64'd0);
    check({tag, ".unf"},   64'(bus.ras_underflow),  64'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.should_run_processor = 1'b1;
    bus.stall      = 1'b0;
    bus.br_mode    = BR_NONE;
    bus.zero       = 1'b0;
    bus.immediate  = '0;
    bus.abs_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;

    // Sequential fetch
    for (int i = 0; i < 3; i++) step("seq", 1, 0, 3'd0, 0, 8'h00, 32'h0);
    check("seq3_abs", 64'(bus.current_pc_out), 64'd3);

    // Conditional branches from PC = 10
    step("jabs10", 1, 0, 3'd4, 0, 8'h00, 32'd10);
    step("beq_t",  1, 0, 3'd1, 1, 8'hFB, 32'h0);
    check("beq_t_abs", 64'(bus.current_pc_out), 64'd6);
    step("jabs10", 1, 0, 3'd4, 0, 8'h00, 32'd10);
    step("beq_nt", 1, 0, 3'd1, 0, 8'hFB, 32'h0);
    check("beq_nt_abs", 64'(bus.current_pc_out), 64'd11);
    step("jabs10", 1, 0, 3'd4, 0, 8'h00, 32'd10);
    step("bne_t",  1, 0, 3'd2, 0, 8'hFB, 32'h0);
    step("bne_nt", 1, 0, 3'd2, 1, 8'hFB, 32'h0);

    // Call / return
    step("jabs20", 1, 0, 3'd4, 0, 8'h00, 32'd20);
    step("call",   1, 0, 3'd5, 0, 8'd9,  32'h0);
    check("call_abs", 64'(bus.current_pc_out), 64'd30);
    step("ret",    1, 0, 3'd6, 0, 8'h00, 32'h0);
    check("ret_abs", 64'(bus.current_pc_out), 64'd21);

    // Overflow, LIFO order and underflow
    step("jabs100", 1, 0, 3'd4, 0, 8'h00, 32'd100);
    for (int i = 0; i < 5; i++) step("ncall", 1, 0, 3'd5, 0, 8'd3, 32'h0);
    check("ovf_abs", 64'(bus.ras_overflow), 64'd1);
    for (int i = 0; i < 4; i++) step("nret", 1, 0, 3'd6, 0, 8'h00, 32'h0);
    check("lifo_last_abs", 64'(bus.current_pc_out), 64'd105);
    step("uret", 1, 0, 3'd6, 0, 8'h00, 32'h0);
    check("unf_abs", 64'(bus.current_pc_out), 64'd106);

    // Run low clears everything, even with stall high
    step("call2a", 1, 0, 3'd5, 0, 8'd1, 32'h0);
    step("call2b", 1, 0, 3'd5, 0, 8'd1, 32'h0);
    step("norun",  0, 1, 3'd4, 0, 8'h00, 32'h55);
    step("restart", 1, 0, 3'd0, 0, 8'h00, 32'h0);

    // Wrap, stall hold, release
    step("jabsmax", 1, 0, 3'd4, 0, 8'h00, 32'hFFFF_FFFF);
    step("wrap",    1, 0, 3'd0, 0, 8'h00, 32'h0);
    check("wrap_abs", 64'(bus.current_pc_out), 64'd0);
    step("stall1",  1, 1, 3'd4, 0, 8'h00, 32'h100);
    step("stall2",  1, 1, 3'd6, 1, 8'h10, 32'h100);
    step("release", 1, 0, 3'd4, 0, 8'h00, 32'h100);
    check("release_abs", 64'(bus.current_pc_out), 64'h100);

    // Self-loop JREL and unlisted encoding
    step("jrel_m1", 1, 0, 3'd3, 0, 8'hFF, 32'h0);
    step("mode7",   1, 0, 3'd7, 1, 8'h20, 32'h300);

    // Asynchronous reset between edges
    step("precall", 1, 0, 3'd5, 0, 8'd4, 32'h0);
    #3 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    model_reset();
    #1 reset = 1'b0;
    step("post_rst", 1, 0, 3'd0, 0, 8'h00, 32'h0);
    check("post_rst_abs", 64'(bus.current_pc_out), 64'd1);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
